// File: rtl/fifo_mem_bank.sv
// fifo_mem_bank: per-channel FIFO word storage with byte enables, per-byte even parity,
// sticky parity error and a saturating count of writes blocked by full.
module fifo_mem_bank #(
    parameter int PTR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int NUM_CH = 2,
    parameter int READ_REG = 0,
    parameter int CLR_ON_RST = 1,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BE_W = DATA_WIDTH / 8
) (
    input  logic                  RST,
    input  logic                  wclk,
    input  logic                  rclk,
    input  logic                  winc,
    input  logic                  wfull,
    input  logic [CH_W-1:0]       wch,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_W-1:0]       wbe,
    input  logic                  par_inv,
    input  logic [CH_W-1:0]       rch,
    input  logic [PTR_WIDTH-1:0]  raddr,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  perr,
    output logic [7:0]            ovf_cnt
);
    logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [BE_W-1:0]       par [NUM_CH][DEPTH];
    logic                  wr_ok, rd_ok, rd_err;
    logic [DATA_WIDTH-1:0] wword, rword;
    logic [BE_W-1:0]       wpar, rpar;

    assign wr_ok = winc && !wfull && (32'(wch) < NUM_CH) && (32'(waddr) < DEPTH);
    assign rd_ok = (32'(rch) < NUM_CH) && (32'(raddr) < DEPTH);

    // Merge enabled lanes into the addressed word so one whole-word store covers any wbe
    always_comb begin
        wword = mem[wch][waddr];
        wpar = par[wch][waddr];
        for (int k = 0; k < BE_W; k++) begin
            wword[8*k +: 8] = wbe[k] ? wdata[8*k +: 8] : wword[8*k +: 8];
            wpar[k] = wbe[k] ? (^wdata[8*k +: 8]) ^ par_inv : wpar[k];
        end
    end

    // Out-of-range reads see zero data with zero parity, so they never flag an error
    assign rword = rd_ok ? mem[rch][raddr] : '0;
    assign rpar = rd_ok ? par[rch][raddr] : '0;

    always_comb begin
        rd_err = 1'b0;
        for (int k = 0; k < BE_W; k++)
            rd_err = rd_err | ((^rword[8*k +: 8]) != rpar[k]);
        rd_err = rd_err && rinc;
    end

    generate
        if (CLR_ON_RST != 0) begin : g_clr
            always_ff @(posedge wclk or negedge RST) begin
                if (!RST) begin
                    for (int c = 0; c < NUM_CH; c++)
                        for (int a = 0; a < DEPTH; a++) begin
                            mem[c][a] <= '0;
                            par[c][a] <= '0;
                        end
                end else if (wr_ok) begin
                    mem[wch][waddr] <= wword;
                    par[wch][waddr] <= wpar;
                end
            end
        end else begin : g_noclr
            always_ff @(posedge wclk) begin
                if (RST && wr_ok) begin
                    mem[wch][waddr] <= wword;
                    par[wch][waddr] <= wpar;
                end
            end
        end
    endgenerate

    always_ff @(posedge wclk or negedge RST) begin
        if (!RST)
            ovf_cnt <= '0;
        else if (winc && wfull && ovf_cnt != 8'hff)
            ovf_cnt <= ovf_cnt + 8'd1;
    end

    generate
        if (READ_REG != 0) begin : g_rreg
            always_ff @(posedge rclk or negedge RST) begin
                if (!RST) begin
                    rdata <= '0;
                    rvalid <= 1'b0;
                    perr <= 1'b0;
                end else if (rinc) begin
                    rdata <= rword;
                    rvalid <= 1'b1;
                    perr <= perr | rd_err;
                end else begin
                    rvalid <= 1'b0;
                end
            end
        end else begin : g_rcomb
            logic unused_rclk;
            assign unused_rclk = rclk;
            assign rdata = RST ? rword : '0;
            assign rvalid = RST && rinc;
            always_ff @(posedge wclk or negedge RST) begin
                if (!RST)
                    perr <= 1'b0;
                else
                    perr <= perr | rd_err;
            end
        end
    endgenerate
endmodule

// File: tb/tb_fifo_mem_bank.sv
// tb_fifo_mem_bank: drives a default (8-bit, combinational read) bank and a 16-bit,
// 3-channel, depth-6 registered-read bank with shared controls, checked against array models.
module tb_fifo_mem_bank;
    logic wclk = 0, rclk = 0, RST = 1;
    logic winc = 0, wfull = 0, par_inv = 0, rinc = 0;
    logic [1:0] wch = 0, rch = 0, wbe = 0;
    logic [2:0] waddr = 0, raddr = 0;
    logic [15:0] wdata = 0;
    logic [7:0] a_rdata, a_ovf, b_ovf;
    logic [15:0] b_rdata;
    logic a_rvalid, a_perr, b_rvalid, b_perr;
    int checks = 0, errors = 0;

    // Reference state: bank A is 2x8 bytes, bank B is 3x6 halfwords; one parity bit per byte
    logic [7:0] ma [2][8];
    logic pa [2][8];
    logic [15:0] mb [3][6];
    logic [1:0] pb [3][6];
    logic [15:0] eb_rdata;
    logic eb_rvalid, ea_perr, eb_perr;
    int e_ovf;

    typedef struct {
        logic winc; logic [1:0] wch; logic [2:0] waddr; logic [15:0] wdata; logic [1:0] wbe;
        logic [1:0] rch; logic [2:0] raddr; logic rinc; logic [7:0] ea; logic [15:0] eb;
    } vec_t;
    vec_t tab [14];

    always #5 wclk = ~wclk;
    always #5 rclk = ~rclk;

    fifo_mem_bank dut_a (
        .RST(RST), .wclk(wclk), .rclk(rclk), .winc(winc), .wfull(wfull), .wch(wch[0]),
        .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0]), .par_inv(par_inv), .rch(rch[0]),
        .raddr(raddr), .rinc(rinc), .rdata(a_rdata), .rvalid(a_rvalid), .perr(a_perr),
        .ovf_cnt(a_ovf));

    fifo_mem_bank #(.DATA_WIDTH(16), .DEPTH(6), .NUM_CH(3), .READ_REG(1)) dut_b (
        .RST(RST), .wclk(wclk), .rclk(rclk), .winc(winc), .wfull(wfull), .wch(wch),
        .waddr(waddr), .wdata(wdata), .wbe(wbe), .par_inv(par_inv), .rch(rch),
        .raddr(raddr), .rinc(rinc), .rdata(b_rdata), .rvalid(b_rvalid), .perr(b_perr),
        .ovf_cnt(b_ovf));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic odd(input logic [7:0] b);
        return ($countones(b) % 2) == 1;
    endfunction

    function automatic logic [7:0] rd_a();
        return ma[rch[0]][raddr];
    endfunction

    function automatic logic [15:0] rd_b();
        if (rch < 3 && raddr < 6)
            return mb[rch][raddr];
        return 16'h0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 8; a++) begin
                if (c < 2) begin
                    ma[c][a] = 0;
                    pa[c][a] = 0;
                end
                if (a < 6) begin
                    mb[c][a] = 0;
                    pb[c][a] = 0;
                end
            end
        eb_rdata = 0;
        eb_rvalid = 0;
        ea_perr = 0;
        eb_perr = 0;
        e_ovf = 0;
    endtask

    // One clock edge of the reference: reads see pre-write contents, then writes land
    task automatic model_edge();
        logic ea_err, eb_err;
        ea_err = rinc && (odd(ma[rch[0]][raddr]) != pa[rch[0]][raddr]);
        eb_err = 0;
        if (rinc && rch < 3 && raddr < 6)
            for (int k = 0; k < 2; k++)
                if (odd(mb[rch][raddr][8*k +: 8]) != pb[rch][raddr][k]) eb_err = 1;
        if (rinc) eb_rdata = rd_b();
        eb_rvalid = rinc;
        ea_perr = ea_perr | ea_err;
        eb_perr = eb_perr | eb_err;
        if (winc && wfull) e_ovf = (e_ovf < 255) ? e_ovf + 1 : 255;
        if (winc && !wfull) begin
            if (wbe[0]) begin
                ma[wch[0]][waddr] = wdata[7:0];
                pa[wch[0]][waddr] = odd(wdata[7:0]) ^ par_inv;
            end
            if (wch < 3 && waddr < 6)
                for (int k = 0; k < 2; k++)
                    if (wbe[k]) begin
                        mb[wch][waddr][8*k +: 8] = wdata[8*k +: 8];
                        pb[wch][waddr][k] = odd(wdata[8*k +: 8]) ^ par_inv;
                    end
        end
    endtask

    task automatic drive(input logic wi, input logic wf, input logic [1:0] wc, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [1:0] be, input logic pi,
                         input logic [1:0] rc, input logic [2:0] ra, input logic ri);
        winc = wi; wfull = wf; wch = wc; waddr = wa; wdata = wd; wbe = be;
        par_inv = pi; rch = rc; raddr = ra; rinc = ri;
    endtask

    // Called at a negedge with inputs applied; returns at the following negedge
    task automatic cyc();
        #1;
        chk("a_rdata", 32'(a_rdata), 32'(rd_a()));
        chk("a_rvalid", 32'(a_rvalid), 32'(rinc));
        @(posedge wclk);
        model_edge();
        @(negedge wclk);
        chk("b_rdata", 32'(b_rdata), 32'(eb_rdata));
        chk("b_rvalid", 32'(b_rvalid), 32'(eb_rvalid));
        chk("a_perr", 32'(a_perr), 32'(ea_perr));
        chk("b_perr", 32'(b_perr), 32'(eb_perr));
        chk("a_ovf", 32'(a_ovf), 32'(e_ovf));
        chk("b_ovf", 32'(b_ovf), 32'(e_ovf));
    endtask

    initial begin
        tab[0]  = '{1'b1, 2'd0, 3'd3, 16'h00A5, 2'b01, 2'd0, 3'd3, 1'b1, 8'h00, 16'h0000};
        tab[1]  = '{1'b1, 2'd1, 3'd3, 16'h3C3C, 2'b11, 2'd0, 3'd3, 1'b1, 8'hA5, 16'h00A5};
        tab[2]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd1, 3'd3, 1'b1, 8'h3C, 16'h3C3C};
        tab[3]  = '{1'b1, 2'd0, 3'd2, 16'h1234, 2'b11, 2'd0, 3'd2, 1'b1, 8'h00, 16'h0000};
        tab[4]  = '{1'b1, 2'd0, 3'd2, 16'hFF00, 2'b10, 2'd0, 3'd2, 1'b1, 8'h34, 16'h1234};
        tab[5]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd0, 3'd2, 1'b1, 8'h34, 16'hFF34};
        tab[6]  = '{1'b1, 2'd0, 3'd2, 16'hFFFF, 2'b00, 2'd0, 3'd2, 1'b1, 8'h34, 16'hFF34};
        tab[7]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd0, 3'd2, 1'b1, 8'h34, 16'hFF34};
        tab[8]  = '{1'b1, 2'd3, 3'd1, 16'hBEEF, 2'b11, 2'd3, 3'd1, 1'b1, 8'h00, 16'h0000};
        tab[9]  = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd1, 3'd1, 1'b1, 8'hEF, 16'h0000};
        tab[10] = '{1'b1, 2'd2, 3'd7, 16'hBEEF, 2'b11, 2'd2, 3'd7, 1'b1, 8'h00, 16'h0000};
        tab[11] = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd0, 3'd7, 1'b1, 8'hEF, 16'h0000};
        tab[12] = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd1, 3'd3, 1'b1, 8'h3C, 16'h3C3C};
        tab[13] = '{1'b0, 2'd0, 3'd0, 16'h0000, 2'b00, 2'd0, 3'd0, 1'b0, 8'h00, 16'h3C3C};
        model_reset();
        #1 RST = 0;
        #1;
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_a_rvalid", 32'(a_rvalid), 0);
        chk("rst_b_rdata", 32'(b_rdata), 0);
        chk("rst_b_rvalid", 32'(b_rvalid), 0);
        chk("rst_perr", 32'({a_perr, b_perr}), 0);
        chk("rst_ovf", 32'({a_ovf, b_ovf}), 0);
        @(negedge wclk);
        RST = 1;

        foreach (tab[i]) begin
            drive(tab[i].winc, 0, tab[i].wch, tab[i].waddr, tab[i].wdata, tab[i].wbe, 0,
                  tab[i].rch, tab[i].raddr, tab[i].rinc);
            #1 chk($sformatf("tab%0d_a", i), 32'(a_rdata), 32'(tab[i].ea));
            cyc();
            chk($sformatf("tab%0d_b", i), 32'(b_rdata), 32'(tab[i].eb));
            chk($sformatf("tab%0d_bv", i), 32'(b_rvalid), 32'(tab[i].rinc));
        end

        // Blocked writes: target word untouched, counter saturates
        drive(1, 1, 0, 3, 16'h5555, 2'b11, 0, 0, 3, 0);
        repeat (300) cyc();
        chk("ovf_a_sat", 32'(a_ovf), 255);
        chk("ovf_b_sat", 32'(b_ovf), 255);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        #1 chk("full_hold_a", 32'(a_rdata), 32'h00A5);
        cyc();
        chk("full_hold_b", 32'(b_rdata), 32'h00A5);

        // Corrupted parity is caught and sticks until reset
        drive(1, 0, 1, 5, 16'h5A5A, 2'b11, 1, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 1);
        cyc();
        chk("perr_a_set", 32'(a_perr), 1);
        chk("perr_b_set", 32'(b_perr), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        repeat (10) cyc();
        chk("perr_a_sticky", 32'(a_perr), 1);
        chk("perr_b_sticky", 32'(b_perr), 1);
        RST = 0;
        #1;
        chk("perr_a_clr", 32'(a_perr), 0);
        chk("perr_b_clr", 32'(b_perr), 0);
        chk("ovf_clr", 32'({a_ovf, b_ovf}), 0);
        model_reset();
        @(negedge wclk);
        RST = 1;

        repeat (400) begin
            drive(1'($urandom), $urandom_range(0, 4) == 0, 2'($urandom), 3'($urandom),
                  16'($urandom), 2'($urandom), $urandom_range(0, 15) == 0,
                  2'($urandom), 3'($urandom), 1'($urandom));
            cyc();
        end

        // Reset while a write and a read are in flight
        drive(1, 0, 0, 4, 16'hC3C3, 2'b11, 0, 0, 4, 1);
        cyc();
        drive(1, 0, 0, 4, 16'h9696, 2'b11, 0, 0, 4, 1);
        #2 RST = 0;
        #1;
        chk("mid_a_rdata", 32'(a_rdata), 0);
        chk("mid_a_rvalid", 32'(a_rvalid), 0);
        chk("mid_b_rdata", 32'(b_rdata), 0);
        chk("mid_b_rvalid", 32'(b_rvalid), 0);
        chk("mid_perr", 32'({a_perr, b_perr}), 0);
        chk("mid_ovf", 32'({a_ovf, b_ovf}), 0);
        model_reset();
        @(negedge wclk);
        RST = 1;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 8; a++) begin
                drive(0, 0, 0, 0, 0, 0, 0, 2'(c), 3'(a), 1);
                #1 chk($sformatf("clr_a_%0d_%0d", c, a), 32'(a_rdata), 0);
                cyc();
                chk($sformatf("clr_b_%0d_%0d", c, a), 32'(b_rdata), 0);
            end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_mem_bank.md
FIFO_MEM_BANK -- requirements
Module: fifo_mem_bank

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- PTR_WIDTH, default 3, address width per channel.
- DATA_WIDTH, default 8, word width; a multiple of 8.
- DEPTH, default 8, words per channel; DEPTH <= 2**PTR_WIDTH.
- NUM_CH, default 2, number of independent channel memories.
- READ_REG, default 0: 0 = combinational read; 1 = registered read on rclk.
- CLR_ON_RST, default 1: 1 = all words and parity bits clear on reset; 0 = memory not reset.
REQ-002 Localparams SHALL be CH_W = max(1, clog2(NUM_CH)) and BE_W = DATA_WIDTH/8.
REQ-003 Ports SHALL be as follows, one per line:
- RST  in  1  reset; asynchronous, active-low.
- wclk  in  1  write clock.
- rclk  in  1  read clock; used only when READ_REG=1.
- winc  in  1  write request.
- wfull  in  1  FIFO full; blocks writes.
- wch  in  CH_W  write channel select.
- waddr  in  PTR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- wbe  in  BE_W  byte enables; bit k covers wdata[8k+7:8k].
- par_inv  in  1  test-only: invert the stored parity on this write.
- rch  in  CH_W  read channel select.
- raddr  in  PTR_WIDTH  read address.
- rinc  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata qualifier.
- perr  out  1  sticky parity error flag.
- ovf_cnt  out  8  saturating count of blocked writes.

Function
REQ-004 Storage SHALL be NUM_CH x DEPTH words of DATA_WIDTH bits, plus one even-parity bit per byte lane per word.
REQ-005 Write accept SHALL occur on posedge wclk when winc=1, wfull=0, wch<NUM_CH and waddr<DEPTH.
REQ-006 On an accepted write, only bytes with wbe[k]=1 SHALL update, together with their parity bits. The stored parity bit SHALL be ^byte XOR par_inv.
REQ-007 Byte lanes with wbe[k]=0 SHALL retain their data and parity. A write with wbe all-zero SHALL change no storage.
REQ-008 Blocked write: on posedge wclk with winc=1 and wfull=1, ovf_cnt SHALL increment by 1 and saturate at 255.
REQ-009 Writes with wch>=NUM_CH or waddr>=DEPTH SHALL be dropped silently and SHALL NOT change ovf_cnt.
REQ-010 READ_REG=0:
- rdata SHALL equal mem[rch][raddr] combinationally.
- rvalid SHALL equal rinc.
REQ-011 READ_REG=1, on posedge rclk:
- rinc=1: rdata <= mem[rch][raddr] and rvalid <= 1.
- rinc=0: rvalid <= 0 and rdata holds.
- Read latency SHALL be 1 rclk.
REQ-012 A read of an out-of-range rch or raddr SHALL return all-zero data and SHALL NOT raise perr.
REQ-013 Parity check SHALL apply to every in-range read with rinc=1. Any byte whose parity mismatches SHALL set perr.
- READ_REG=0: perr sets on the next posedge wclk.
- READ_REG=1: perr sets on the same posedge rclk that loads rdata.
REQ-014 perr SHALL be sticky until RST and SHALL clear only on reset.
REQ-015 Simultaneous write and read of the same channel and address:
- READ_REG=0: rdata SHALL reflect the new word after the wclk edge.
- READ_REG=1 with coincident edges: rdata SHALL return the old word (read-before-write).
REQ-016 A write and a read of different channels SHALL be fully independent.

Reset
REQ-017 RST low SHALL asynchronously force:
- rdata=0, rvalid=0, perr=0, ovf_cnt=0.
- If CLR_ON_RST=1, all data and parity bits to 0.
REQ-018 A write or read in progress when RST asserts SHALL be discarded. Storage is not defined for CLR_ON_RST=0.
REQ-019 Release of RST SHALL take effect at the first posedge of each clock after deassertion; no other state SHALL need reinitialisation.

Verification
REQ-020 Default parameters:
- Reset, then write 0xA5 to ch0 addr3 and 0x3C to ch1 addr3.
- Read ch0/3 -> 0xA5; read ch1/3 -> 0x3C; perr=0.
REQ-021 DATA_WIDTH=16:
- Write 0x1234, then write 0xFF00 with wbe=2'b10.
- Read -> 0xFF34.
REQ-022 Hold wfull=1 with winc=1 for 300 wclk cycles:
- Target word unchanged.
- ovf_cnt = 255.
REQ-023 Write 0x5A with par_inv=1, then read it:
- perr = 1.
- perr stays 1 after 10 further clean reads, until RST pulses low, then 0.
REQ-024 READ_REG=1:
- Assert rinc at cycle n with addr 2 holding 0x77.
- rdata = 0x77 and rvalid = 1 at cycle n+1.
- rvalid = 0 at n+2 when rinc=0.
REQ-025 Reset mid-operation:
- Assert RST low mid-write, with CLR_ON_RST=1.
- All outputs are 0 immediately.
- A read of every address after release -> 0.
